// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator: pixel prescaler, horizontal/vertical counters,
// registered sync / active decodes and line / frame strobes. Every output is
// a flop, and all decodes describe the coordinate presented in the same cycle.
//
// Optional build macro: VGA_FRAME_COUNTER_EN
//   defined   -> adds frame_cnt[7:0], the frame index used as scroll phase
//   undefined -> no frame counter port or logic
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 128,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 9,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 28,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       pix_stb,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DIV_TOP  = 4'(CLK_DIV - 1);

  // Geometry outside the supported range stops elaboration.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_params
    $fatal(1, "vga_timing_gen: illegal geometry or CLK_DIV");
  end

  logic [3:0] r_div;
  logic       r_run;          // set once the origin has been presented
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_active;
  logic       r_pix_stb;
  logic       r_line_start;
  logic       r_frame_start;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] r_frame_cnt;
`endif

  logic       w_tick;
  logic [3:0] w_div_next;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_hs_on;
  logic       w_vs_on;
  logic       w_act_next;

  // The pixel advances on the edge where the prescaler sits at its top count.
  assign w_tick     = en && (r_div == DIV_TOP);
  assign w_div_next = (r_div == DIV_TOP) ? 4'd0 : r_div + 4'd1;

  // Next coordinate: the first pixel after a restart is the origin itself.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    w_x_next = r_x;
    w_y_next = r_y;
    if (!r_run) begin
      w_x_next = '0;
      w_y_next = '0;
    end else if (r_x == H_LAST) begin
      w_x_next = '0;
      w_y_next = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
    end else begin
      w_x_next = r_x + 10'd1;
    end
  end

  // Decodes are taken from the next coordinate so they line up with it once registered.
  assign w_hs_on    = (w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST);
  assign w_vs_on    = (w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST);
  assign w_act_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);

  // Raster state: async reset, synchronous idle while en is low, advance on each pixel tick.
  always_ff @(posedge clock or negedge resetb) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!resetb) begin
      r_div         <= '0;
      r_run         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_active      <= 1'b0;
      r_pix_stb     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef VGA_FRAME_COUNTER_EN
      r_frame_cnt   <= '0;
`endif
    end else if (!en) begin
      r_div         <= '0;
      r_run         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_active      <= 1'b0;
      r_pix_stb     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_next;
      r_pix_stb     <= w_tick;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_tick) begin
        r_run         <= 1'b1;
        r_x           <= w_x_next;
        r_y           <= w_y_next;
        r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
        r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
        r_active      <= w_act_next;
        r_line_start  <= (w_x_next == 10'd0);
        r_frame_start <= (w_x_next == 10'd0) && (w_y_next == 10'd0);
`ifdef VGA_FRAME_COUNTER_EN
        // The restart frame keeps the held count; later frames step it.
        if (r_run && (w_x_next == 10'd0) && (w_y_next == 10'd0)) begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
`endif
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign x_pos       = r_x;
  assign y_pos       = r_y;
  assign pix_stb     = r_pix_stb;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
`ifdef VGA_FRAME_COUNTER_EN
  assign frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Three instances share clock and reset:
//   d_ : default 640x480 geometry, CLK_DIV = 1 (horizontal, en, reset)
//   q_ : default geometry, CLK_DIV = 4 (prescaler and strobe width)
//   s_ : 16 x 12 raster (8x6 visible) for frame-level timing in few cycles
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clock = 1'b0;
  logic resetb;
  logic en_d, en_q, en_s;

  always #5 clock = ~clock;

  logic       d_hsync, d_vsync, d_active, d_pix_stb, d_line_start, d_frame_start;
  logic [9:0] d_x, d_y;
  logic       q_hsync, q_vsync, q_active, q_pix_stb, q_line_start, q_frame_start;
  logic [9:0] q_x, q_y;
  logic       s_hsync, s_vsync, s_active, s_pix_stb, s_line_start, s_frame_start;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] d_fc, q_fc, s_fc;
`endif

  vga_timing_gen dut (
    .clock(clock), .resetb(resetb), .en(en_d),
    .hsync(d_hsync), .vsync(d_vsync), .active(d_active),
    .x_pos(d_x), .y_pos(d_y), .pix_stb(d_pix_stb),
    .line_start(d_line_start), .frame_start(d_frame_start)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(.CLK_DIV(4)) dut_div4 (
    .clock(clock), .resetb(resetb), .en(en_q),
    .hsync(q_hsync), .vsync(q_vsync), .active(q_active),
    .x_pos(q_x), .y_pos(q_y), .pix_stb(q_pix_stb),
    .line_start(q_line_start), .frame_start(q_frame_start)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(q_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_small (
    .clock(clock), .resetb(resetb), .en(en_s),
    .hsync(s_hsync), .vsync(s_vsync), .active(s_active),
    .x_pos(s_x), .y_pos(s_y), .pix_stb(s_pix_stb),
    .line_start(s_line_start), .frame_start(s_frame_start)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(s_fc)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) until the default instance presents coordinate (x, y).
  task automatic wait_d(input string tag, input int x, input int y, input int budget);
    int n = 0;
    while (!(d_x == 10'(x) && d_y == 10'(y)) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_reached"}, (d_x == 10'(x) && d_y == 10'(y)) ? 1 : 0, 1);
  endtask

  // Called on the sample where a default-geometry line starts (x = 0, row y0).
  task automatic measure_d(input string tag, input int y0);
    int hs_first = -1;
    int hs_x     = -1;
    int hs_cnt   = 0;
    int act_cnt  = 0;
    int ls_cnt   = 0;
    for (int i = 0; i < 832; i++) begin
      if (d_hsync === 1'b0) begin
        if (hs_first < 0) begin
          hs_first = i;
          hs_x     = int'(d_x);
        end
        hs_cnt++;
      end
      if (d_active === 1'b1)     act_cnt++;
      if (d_line_start === 1'b1) ls_cnt++;
      @(negedge clock);
    end
    check({tag, "_hs_start_clk"}, hs_first, 664);
    check({tag, "_hs_start_x"},   hs_x,     664);
    check({tag, "_hs_width"},     hs_cnt,   40);
    check({tag, "_active_cnt"},   act_cnt,  640);
    check({tag, "_ls_cnt"},       ls_cnt,   1);
    check({tag, "_period_ls"},    d_line_start, 1);
    check({tag, "_period_x"},     d_x,      0);
    check({tag, "_period_y"},     d_y,      y0 + 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    int stb_cnt, ls_cnt, gap_bad, last_stb, x3, x4;
    int vs_first, vs_x, vs_cnt, vs_rise, fs_cnt;

    resetb = 1'b0;
    en_d   = 1'b0;
    en_q   = 1'b0;
    en_s   = 1'b0;
    repeat (3) @(negedge clock);

    // ---- reset state ----
    check("rst_x",           d_x,           0);
    check("rst_y",           d_y,           0);
    check("rst_hsync",       d_hsync,       1);
    check("rst_vsync",       d_vsync,       1);
    check("rst_active",      d_active,      0);
    check("rst_pix_stb",     d_pix_stb,     0);
    check("rst_line_start",  d_line_start,  0);
    check("rst_frame_start", d_frame_start, 0);

    resetb = 1'b1;
    @(negedge clock);
    check("idle_no_fs", d_frame_start, 0);

    // ---- start from origin, default geometry ----
    en_d = 1'b1;
    @(negedge clock);
    check("start_fs",      d_frame_start, 1);
    check("start_ls",      d_line_start,  1);
    check("start_pix_stb", d_pix_stb,     1);
    check("start_active",  d_active,      1);
    check("start_x",       d_x,           0);
    check("start_y",       d_y,           0);
    measure_d("l0", 0);

    // ---- en dropped at (300, 1), held low for 50 clocks ----
    wait_d("en_drop", 300, 1, 2000);
    en_d = 1'b0;
    @(negedge clock);
    check("idle_x",      d_x,      0);
    check("idle_y",      d_y,      0);
    check("idle_hsync",  d_hsync,  1);
    check("idle_active", d_active, 0);
    check("idle_stb",    d_pix_stb, 0);
    bad = 0;
    repeat (49) begin
      @(negedge clock);
      if (d_x !== 10'd0 || d_y !== 10'd0 || d_hsync !== 1'b1 || d_vsync !== 1'b1 ||
          d_active !== 1'b0 || d_pix_stb !== 1'b0 || d_line_start !== 1'b0 ||
          d_frame_start !== 1'b0) bad++;
    end
    check("idle_hold_bad", bad, 0);
    en_d = 1'b1;
    @(negedge clock);
    check("reen_fs", d_frame_start, 1);
    check("reen_x",  d_x, 0);
    check("reen_y",  d_y, 0);
    measure_d("reen", 0);

    // ---- async reset mid-line at x = 500 ----
    wait_d("rst_mid", 500, 1, 1000);
    #1 resetb = 1'b0;
    #1;
    check("arst_x",      d_x,       0);
    check("arst_y",      d_y,       0);
    check("arst_active", d_active,  0);
    check("arst_stb",    d_pix_stb, 0);
    check("arst_hsync",  d_hsync,   1);
    @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    check("post_rst_fs", d_frame_start, 1);
    check("post_rst_x",  d_x, 0);
    measure_d("rst", 0);
    en_d = 1'b0;

    // ---- CLK_DIV = 4 ----
    en_q = 1'b1;
    n = 0;
    while (q_pix_stb !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("q_first_stb_clks", n, 4);
    check("q_first_fs",       q_frame_start, 1);
    check("q_first_x",        q_x, 0);
    stb_cnt = 0; ls_cnt = 0; gap_bad = 0; last_stb = -4; x3 = -1; x4 = -1;
    for (int i = 0; i < 3328; i++) begin
      if (q_pix_stb === 1'b1) begin
        stb_cnt++;
        if (i - last_stb != 4) gap_bad++;
        last_stb = i;
      end
      if (q_line_start === 1'b1) ls_cnt++;
      if (i == 3) x3 = int'(q_x);
      if (i == 4) x4 = int'(q_x);
      @(negedge clock);
    end
    check("q_stb_cnt",  stb_cnt, 832);
    check("q_stb_gap",  gap_bad, 0);
    check("q_ls_width", ls_cnt,  1);
    check("q_x_hold",   x3,      0);
    check("q_x_step",   x4,      1);
    check("q_period_ls", q_line_start, 1);
    check("q_period_y",  q_y, 1);
    en_q = 1'b0;

    // ---- vertical timing on the small raster (16 x 12, frame 192 clocks) ----
    en_s = 1'b1;
    @(negedge clock);
    check("s_fs", s_frame_start, 1);
`ifdef VGA_FRAME_COUNTER_EN
    check("fc_frame0", s_fc, 0);
`endif
    vs_first = -1; vs_x = -1; vs_cnt = 0; vs_rise = -1; fs_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      if (s_vsync === 1'b0) begin
        if (vs_first < 0) begin
          vs_first = i;
          vs_x     = int'(s_x);
        end
        vs_cnt++;
      end else if (vs_first >= 0 && vs_rise < 0) begin
        vs_rise = i;
      end
      if (s_frame_start === 1'b1) fs_cnt++;
      @(negedge clock);
    end
    check("s_vs_start", vs_first, 128);
    check("s_vs_x",     vs_x,     0);
    check("s_vs_width", vs_cnt,   32);
    check("s_vs_end",   vs_rise,  160);
    check("s_fs_cnt",   fs_cnt,   1);
    check("s_fs_period", s_frame_start, 1);
    check("s_frame_x",  s_x, 0);
    check("s_frame_y",  s_y, 0);

`ifdef VGA_FRAME_COUNTER_EN
    check("fc_frame1", s_fc, 1);
    for (int f = 2; f <= 257; f++) begin
      repeat (192) @(negedge clock);
      if (f == 255) check("fc_frame255", s_fc, 255);
      if (f == 256) check("fc_wrap256",  s_fc, 0);
    end
    check("fc_frame257", s_fc, 1);
    check("fc_frame257_fs", s_frame_start, 1);
    en_s = 1'b0;
    repeat (20) @(negedge clock);
    check("fc_en_low", s_fc, 1);
    en_s = 1'b1;
    @(negedge clock);
    check("fc_restart_fs", s_frame_start, 1);
    check("fc_restart",    s_fc, 1);
    repeat (192) @(negedge clock);
    check("fc_after_restart", s_fc, 2);
`endif
    en_s = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
